// File: rtl/fft_r4_engine.sv
// fft_r4_engine: radix-4 butterfly engine on the openMSP430 peripheral bus.
// The CPU loads NCH complex 4-point groups through an indexed DATA port,
// writes START, and the engine computes one channel per cycle. Results are
// read back through the same port. Optional feature macro: FFT_R4_IRQ_EN
// (adds the irq_fft output and a read/write CTRL.IRQ_EN bit).
module fft_r4_engine #(
    parameter int          DW        = 16,
    parameter int          NCH       = 4,
    parameter logic [13:0] BASE_ADDR = 14'h88
) (
    input  logic        mclk,
    input  logic        puc_rst_n,
    input  logic [13:0] per_addr,
    input  logic [15:0] per_din,
    input  logic        per_en,
    input  logic [1:0]  per_we,
    output logic [15:0] per_dout
`ifdef FFT_R4_IRQ_EN
    ,
    output logic        irq_fft
`endif
);

    localparam int IW = DW + 2;
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic signed [IW-1:0] SAT_MAX = IW'((2 ** (DW - 1)) - 1);
    localparam logic signed [IW-1:0] SAT_MIN = IW'(-(2 ** (DW - 1)));

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic signed [DW-1:0] inbuf  [NCH][8];
    logic signed [DW-1:0] outbuf [NCH][8];
    logic [3:0]           ch;
    logic [2:0]           idx;
    logic [CW-1:0]        run_k;
    logic                 scale;
    logic                 irq_en;
    logic                 done;
    logic                 ovf;

    // Bus decode
    logic [13:0] offset;
    logic [1:0]  off;
    logic        hit, wr, rd;
    logic        ctrl_wr, status_wr, ptr_wr, data_wr, data_acc;
    logic        busy, start;
    logic [3:0]  ch_wr;

    assign offset    = per_addr - BASE_ADDR;
    assign off       = offset[1:0];
    assign hit       = per_en && (offset < 14'd4);
    assign wr        = hit && (per_we == 2'b11);
    assign rd        = hit && (per_we == 2'b00);
    assign ctrl_wr   = wr && (off == 2'd0);
    assign status_wr = wr && (off == 2'd1);
    assign ptr_wr    = wr && (off == 2'd2);
    assign data_wr   = wr && (off == 2'd3);
    assign data_acc  = (wr || rd) && (off == 2'd3);
    assign busy      = (state == S_RUN);
    assign start     = ctrl_wr && per_din[0] && (state == S_IDLE);
    // Channel numbers beyond the configured count fold back into range.
    assign ch_wr     = 4'(32'(per_din[3:0]) % NCH);

    // Butterfly datapath for the channel selected by the run counter
    logic signed [IW-1:0] pt [8];
    logic signed [IW-1:0] bf [8];
    logic signed [DW-1:0] res [8];
    logic                 clip_any;

    // Sign-extend inputs and form the four radix-4 outputs at full width
    always_comb begin
        for (int p = 0; p < 8; p++) pt[p] = IW'(inbuf[run_k][p]);
        bf[0] = pt[0] + pt[2] + pt[4] + pt[6];
        bf[1] = pt[1] + pt[3] + pt[5] + pt[7];
        bf[2] = pt[0] + pt[3] - pt[4] - pt[7];
        bf[3] = pt[1] - pt[2] - pt[5] + pt[6];
        bf[4] = pt[0] - pt[2] + pt[4] - pt[6];
        bf[5] = pt[1] - pt[3] + pt[5] - pt[7];
        bf[6] = pt[0] - pt[3] - pt[4] + pt[7];
        bf[7] = pt[1] + pt[2] - pt[5] - pt[6];
    end

    // Reduce each component to DW bits by scaling (/4, floor) or saturating
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        clip_any = 1'b0;
        for (int p = 0; p < 8; p++) begin
            res[p] = '0;
            if (scale) begin
                res[p] = DW'(bf[p] >>> 2);
            end else if (bf[p] > SAT_MAX) begin
                res[p]   = DW'(SAT_MAX);
                clip_any = 1'b1;
            end else if (bf[p] < SAT_MIN) begin
                res[p]   = DW'(SAT_MIN);
                clip_any = 1'b1;
            end else begin
                res[p] = bf[p][DW-1:0];
            end
        end
    end

    // FSM state register
    always_ff @(posedge mclk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!puc_rst_n) state <= S_IDLE;
        else            state <= state_nxt;
    end

    // FSM next-state: IDLE -> RUN on START, RUN for NCH cycles, one DONE cycle
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (run_k == CW'(NCH - 1)) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Registers, pointer, buffers and status flags
    always_ff @(posedge mclk) begin
        if (!puc_rst_n) begin
            scale <= 1'b0;
            done  <= 1'b0;
            ovf   <= 1'b0;
            ch    <= '0;
            idx   <= '0;
            run_k <= '0;
            // NOTE: the buffers are reset because software must read zeros after reset; this keeps them in flops, not RAM.
            for (int c = 0; c < NCH; c++) begin
                for (int p = 0; p < 8; p++) begin
                    inbuf[c][p]  <= '0;
                    outbuf[c][p] <= '0;
                end
            end
        end else begin
            if (ctrl_wr && !busy) scale <= per_din[1];

            // Clears are applied before sets so a coincident set wins.
            if (status_wr && per_din[1]) done <= 1'b0;
            if (start)                   done <= 1'b0;
            if (state == S_DONE)         done <= 1'b1;

            if (status_wr && per_din[2]) ovf <= 1'b0;
            if (busy && clip_any)        ovf <= 1'b1;

            if (ptr_wr) begin
                ch  <= ch_wr;
                idx <= per_din[6:4];
            end else if (data_acc) begin
                idx <= idx + 3'd1;
                if (idx == 3'd7) ch <= (ch == 4'(NCH - 1)) ? 4'd0 : ch + 4'd1;
            end

            if (data_wr && !busy) inbuf[ch[CW-1:0]][idx] <= per_din[DW-1:0];

            if (start) begin
                run_k <= '0;
            end else if (busy) begin
                for (int p = 0; p < 8; p++) outbuf[run_k][p] <= res[p];
                run_k <= run_k + 1'b1;
            end
        end
    end

`ifdef FFT_R4_IRQ_EN
    // Interrupt enable is writable at any time, including while busy
    always_ff @(posedge mclk) begin
        if (!puc_rst_n)   irq_en <= 1'b0;
        else if (ctrl_wr) irq_en <= per_din[2];
    end

    assign irq_fft = done & irq_en;
`else
    assign irq_en = 1'b0;
`endif

    // Read mux: zero unless a read cycle addresses this block
    always_comb begin
        per_dout = '0;
        if (rd) begin
            case (off)
                2'd0:    per_dout = {13'b0, irq_en, scale, 1'b0};
                2'd1:    per_dout = {13'b0, ovf, done, busy};
                2'd2:    per_dout = {9'b0, idx, ch};
                default: per_dout = 16'(outbuf[ch[CW-1:0]][idx]);
            endcase
        end
    end

endmodule

// File: tb/tb_fft_r4_engine.sv
// tb_fft_r4_engine: scoreboard bench for fft_r4_engine. Bus reads push the
// expected word into a queue; a negedge monitor pops and compares per_dout.
// Expected data comes from a 4-point DFT reference model with twiddles.
`timescale 1ns/1ps
module tb_fft_r4_engine;

    localparam int          DW   = 16;
    localparam int          NCH  = 4;
    localparam logic [13:0] BASE = 14'h88;
    localparam int          SMAX = (2 ** (DW - 1)) - 1;
    localparam int          SMIN = -(2 ** (DW - 1));

    logic        mclk      = 1'b0;
    logic        puc_rst_n = 1'b0;
    logic [13:0] per_addr  = '0;
    logic [15:0] per_din   = '0;
    logic        per_en    = 1'b0;
    logic [1:0]  per_we    = '0;
    logic [15:0] per_dout;
`ifdef FFT_R4_IRQ_EN
    logic        irq_fft;
`endif

    fft_r4_engine #(.DW(DW), .NCH(NCH), .BASE_ADDR(BASE)) dut (
        .mclk      (mclk),
        .puc_rst_n (puc_rst_n),
        .per_addr  (per_addr),
        .per_din   (per_din),
        .per_en    (per_en),
        .per_we    (per_we),
        .per_dout  (per_dout)
`ifdef FFT_R4_IRQ_EN
        ,
        .irq_fft   (irq_fft)
`endif
    );

    always #5 mclk = ~mclk;

    typedef struct {
        string       name;
        logic [15:0] exp;
        logic [15:0] mask;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   total = 0;
    int   bad   = 0;

    // Reference model state
    int m_in  [NCH][8];
    int m_out [NCH][8];
    int m_ch, m_idx;
    bit m_scale, m_irq_en, m_done, m_ovf, m_busy;

    task automatic check(string name, logic [15:0] act, logic [15:0] exp, logic [15:0] mask);
        total++;
        if ((act & mask) !== (exp & mask)) begin
            bad++;
            $display("FAIL %s: got %h expected %h (mask %h)", name, act, exp, mask);
        end
    endtask

    // Monitor: every read cycle on the bus consumes one expectation
    always @(negedge mclk) begin
        if (per_en && per_we == 2'b00) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_underflow: got %h expected no read", per_dout);
            end else begin
                cur = sb.pop_front();
                check(cur.name, per_dout, cur.exp, cur.mask);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic void model_reset();
        for (int c = 0; c < NCH; c++)
            for (int p = 0; p < 8; p++) begin
                m_in[c][p]  = 0;
                m_out[c][p] = 0;
            end
        m_ch = 0; m_idx = 0;
        m_scale = 0; m_irq_en = 0; m_done = 0; m_ovf = 0; m_busy = 0;
    endfunction

    function automatic int sx(logic [15:0] d);
        logic signed [DW-1:0] t;
        t = d[DW-1:0];
        return int'(t);
    endfunction

    function automatic void advance();
        if (m_idx == 7) begin
            m_idx = 0;
            m_ch  = (m_ch + 1) % NCH;
        end else begin
            m_idx++;
        end
    endfunction

    function automatic int shape(int v);
        if (m_scale) return v >>> 2;
        if (v > SMAX) begin m_ovf = 1; return SMAX; end
        if (v < SMIN) begin m_ovf = 1; return SMIN; end
        return v;
    endfunction

    // X[k] = sum_n x[n] * (-j)^(n*k), applied to every channel
    function automatic void model_run();
        int sr, si, xr, xi;
        for (int c = 0; c < NCH; c++) begin
            for (int k = 0; k < 4; k++) begin
                sr = 0; si = 0;
                for (int n = 0; n < 4; n++) begin
                    xr = m_in[c][2*n];
                    xi = m_in[c][2*n+1];
                    case ((n * k) % 4)
                        0:       begin sr += xr; si += xi; end
                        1:       begin sr += xi; si -= xr; end
                        2:       begin sr -= xr; si -= xi; end
                        default: begin sr -= xi; si += xr; end
                    endcase
                end
                m_out[c][2*k]   = shape(sr);
                m_out[c][2*k+1] = shape(si);
            end
        end
        m_done = 1;
    endfunction

    function automatic logic [15:0] model_read(int off);
        case (off)
            0:       return {13'b0, m_irq_en, m_scale, 1'b0};
            1:       return {13'b0, m_ovf, m_done, m_busy};
            2:       return {9'b0, 3'(m_idx), 4'(m_ch)};
            3:       return 16'(m_out[m_ch][m_idx]);
            default: return 16'h0;
        endcase
    endfunction

    // ---------------- bus stimulus ----------------
    task automatic drive(logic [13:0] addr, logic [1:0] we, logic [15:0] d);
        per_addr = addr;
        per_we   = we;
        per_din  = d;
        per_en   = 1'b1;
        @(posedge mclk);
        #1;
        per_en = 1'b0;
        per_we = 2'b00;
    endtask

    task automatic idle();
        @(posedge mclk);
        #1;
    endtask

    task automatic reg_write(int off, logic [15:0] d);
        case (off)
            0: begin
                if (!m_busy) m_scale = d[1];
`ifdef FFT_R4_IRQ_EN
                m_irq_en = d[2];
`endif
                if (d[0] && !m_busy) model_run();
            end
            1: begin
                if (d[1]) m_done = 0;
                if (d[2]) m_ovf  = 0;
            end
            2: begin
                m_ch  = int'(d[3:0]) % NCH;
                m_idx = int'(d[6:4]);
            end
            default: begin
                if (!m_busy) m_in[m_ch][m_idx] = sx(d);
                advance();
            end
        endcase
        drive(BASE + 14'(off), 2'b11, d);
    endtask

    task automatic expect_read(logic [13:0] addr, logic [15:0] exp, logic [15:0] mask, string name);
        exp_t e;
        e.name = name; e.exp = exp; e.mask = mask;
        sb.push_back(e);
        drive(addr, 2'b00, 16'h0);
    endtask

    task automatic reg_read(int off, string name);
        logic [15:0] e;
        e = model_read(off);
        if (off == 3) advance();
        expect_read(BASE + 14'(off), e, 16'hFFFF, name);
    endtask

    // mode 0: plain run; 1: START and DATA writes while busy; 2: DONE clear collides with DONE set
    task automatic run(bit scale, int mode);
        reg_write(0, {13'b0, m_irq_en, scale, 1'b1});
        m_busy = 1;
        for (int i = 0; i < NCH; i++) begin
            if (mode == 1 && i == 0)      reg_write(0, {13'b0, m_irq_en, ~scale, 1'b1});
            else if (mode == 1 && i == 1) reg_write(3, 16'($urandom));
            else                          expect_read(BASE + 14'd1, 16'h1, 16'h3, "busy_window");
        end
        m_busy = 0;
        if (mode == 2) drive(BASE + 14'd1, 2'b11, 16'h0002);
        else           expect_read(BASE + 14'd1, 16'h0, 16'h3, "done_gap");
        reg_read(1, "status_after_run");
    endtask

    task automatic load_ch0(int ar, int ai, int br, int bi, int cr, int ci, int dr, int di);
        reg_write(2, 16'h0);
        reg_write(3, 16'(ar)); reg_write(3, 16'(ai));
        reg_write(3, 16'(br)); reg_write(3, 16'(bi));
        reg_write(3, 16'(cr)); reg_write(3, 16'(ci));
        reg_write(3, 16'(dr)); reg_write(3, 16'(di));
    endtask

    task automatic read_outputs(int n, string name);
        reg_write(2, 16'h0);
        for (int i = 0; i < n; i++) reg_read(3, name);
    endtask

    task automatic fill_random(bit wide);
        reg_write(2, 16'h0);
        for (int i = 0; i < 8 * NCH; i++) begin
            if (wide) reg_write(3, 16'($urandom));
            else      reg_write(3, 16'($urandom_range(0, 4095)) - 16'd2048);
        end
    endtask

    task automatic check_irq(string name);
`ifdef FFT_R4_IRQ_EN
        check(name, {15'b0, irq_fft}, {15'b0, m_done & m_irq_en}, 16'h0001);
`endif
    endtask

    // ---------------- test sequence ----------------
    initial begin
        model_reset();
        repeat (3) @(posedge mclk);
        #1;
        puc_rst_n = 1'b1;

        reg_read(0, "ctrl_reset");
        reg_read(1, "status_reset");
        reg_read(2, "ptr_reset");
        reg_read(3, "data_reset");
        expect_read(BASE + 14'd4, 16'h0, 16'hFFFF, "unaddressed_hi");
        expect_read(BASE - 14'd1, 16'h0, 16'hFFFF, "unaddressed_lo");

        // Directed vector, saturating then scaled
        load_ch0(100, 0, 200, 0, 300, 0, 400, 0);
        run(1'b0, 0);
        read_outputs(8, "x_dir_sat");
        run(1'b1, 0);
        read_outputs(8, "x_dir_scale");
        reg_read(0, "ctrl_scale");

        // Saturation, sticky OVF, selective clears
        load_ch0(16384, 0, 16384, 0, 16384, 0, 16384, 0);
        run(1'b0, 0);
        read_outputs(8, "x_clip");
        reg_write(1, 16'h0002);
        reg_read(1, "ovf_sticky");
        reg_write(1, 16'h0004);
        reg_read(1, "ovf_cleared");
        run(1'b1, 0);
        read_outputs(8, "x_clip_scaled");

        // Pointer wrap: 32 writes return to 0, the 33rd lands on ch0 IDX0
        fill_random(1'b1);
        reg_read(2, "ptr_wrap");
        reg_write(3, 16'($urandom));
        reg_read(2, "ptr_after_33");
        drive(BASE + 14'd2, 2'b01, 16'h0035);
        reg_read(2, "ptr_byte_write_ignored");
        run(1'b0, 0);
        read_outputs(8 * NCH, "x_wrap");

        // Busy behaviour and DONE set/clear collision
        fill_random(1'b0);
        run(1'b1, 1);
        reg_read(0, "ctrl_scale_kept");
        read_outputs(8 * NCH, "x_busy");
        fill_random(1'b1);
        run(1'b0, 2);
        read_outputs(8 * NCH, "x_collide");

        // Randomized runs
        for (int r = 0; r < 4; r++) begin
            fill_random(r[0]);
            if (r == 2) reg_write(1, 16'h0006);
            run(1'($urandom), r % 2);
            read_outputs(8 * NCH, "x_rand");
            reg_write(2, 16'h0036);
            reg_read(3, "data_ch_fold");
        end

        reg_write(0, 16'h0004);
        reg_read(0, "ctrl_irq_bit");
        check_irq("irq_enabled_done");
        reg_write(1, 16'h0002);
        check_irq("irq_cleared");
        run(1'b0, 0);
        check_irq("irq_after_run");
        reg_write(1, 16'h0002);
        check_irq("irq_after_clear");
        reg_write(0, 16'h0000);

        // Reset asserted mid-run
        fill_random(1'b1);
        reg_write(0, 16'h0001);
        idle();
        idle();
        puc_rst_n = 1'b0;
        idle();
        idle();
        puc_rst_n = 1'b1;
        model_reset();
        reg_read(1, "status_mid_reset");
        reg_read(2, "ptr_mid_reset");
        reg_read(0, "ctrl_mid_reset");
        for (int i = 0; i < 8 * NCH; i++) reg_read(3, "data_mid_reset");
        for (int i = 0; i < NCH + 2; i++) reg_read(1, "no_busy_after_reset");
        check_irq("irq_after_reset");

        for (int i = 0; i < 10 && sb.size() != 0; i++) idle();
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
